bus_responder: RTL



---
 rtl/bus_responder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - CPU bus target endpoint: scratchpad, timed peripheral port, unmapped region
module bus_responder #(
  parameter int          SRAM_AW  = 10,
  parameter logic [3:0]  PER_BASE = 4'b1000,
  parameter logic [15:0] TIMEOUT  = 16'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [26:0] bus_addr,
  input  logic [31:0] bus_data,
  input  logic        bus_we,
  input  logic        bus_start,
  output logic [31:0] bus_q,
  output logic        bus_done,
  output logic        bus_err,
  output logic [22:0] per_addr,
  output logic [31:0] per_data,
  output logic        per_we,
  output logic        per_start,
  input  logic [31:0] per_q,
  input  logic        per_done
);

  typedef enum logic [2:0] {IDLE, SRAM_RD, PER_REQ, PER_WAIT, RESP} state_t;

  state_t      state, state_nxt, decode_state;
  logic [31:0] mem [0:(1 << SRAM_AW) - 1];
  logic [22:0] addr_q;
  logic [31:0] data_q;
  logic        we_q;
  logic [31:0] resp_q;
  logic        err_q;
  logic [15:0] cnt_q;
  logic        accept;
  logic        is_sram;
  logic        is_per;
  logic        timed_out;

  // Requests are only taken when nothing is in flight; starts elsewhere are dropped.
  assign accept    = bus_start && (state == IDLE || state == RESP);
  assign is_sram   = (bus_addr >> SRAM_AW) == '0;
  assign is_per    = bus_addr[26:23] == PER_BASE;
  assign timed_out = cnt_q == (TIMEOUT - 16'd1);

  always_comb begin
    decode_state = RESP;
    if (is_sram)
      decode_state = SRAM_RD;
    else if (is_per)
      decode_state = PER_REQ;
  end

  always_comb begin
    state_nxt = state;
    per_start = 1'b0;
    bus_done  = 1'b0;
    case (state)
      IDLE:     if (accept) state_nxt = decode_state;
      SRAM_RD:  state_nxt = RESP;
      PER_REQ: begin
        per_start = 1'b1;
        state_nxt = PER_WAIT;
      end
      PER_WAIT: if (per_done || timed_out) state_nxt = RESP;
      RESP: begin
        bus_done  = 1'b1;
        state_nxt = accept ? decode_state : IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  assign bus_q    = (bus_done && !we_q) ? resp_q : 32'h0;
  assign bus_err  = bus_done && err_q;
  assign per_addr = addr_q;
  assign per_data = data_q;
  assign per_we   = we_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      resp_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= bus_addr[22:0];
        data_q <= bus_data;
        we_q   <= bus_we;
        resp_q <= '0;
        err_q  <= 1'b0;
      end else begin
        case (state)
          SRAM_RD:  if (!we_q) resp_q <= mem[addr_q[SRAM_AW-1:0]];
          PER_REQ:  cnt_q <= '0;
          PER_WAIT: begin
            if (per_done) begin
              resp_q <= per_q;
            end else begin
              cnt_q <= cnt_q + 16'd1;
              if (timed_out) begin
                resp_q <= '0;
                err_q  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Scratchpad has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (state == SRAM_RD && we_q)
      mem[addr_q[SRAM_AW-1:0]] <= data_q;
  end

endmodule
